// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// ALU operation classes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OR    = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_ADDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational decode of FSM state into datapath control strobes and selects.
module ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  logic       reset,
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] op_held,
  input  logic       ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_RTYPE;
    illegal_op    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOP_ADD;
          // PC+4 and IR load only commit once the fetch completes
          ir_write  = ready;
          pc_write  = ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH2;
          alu_op     = ALUOP_ADD;
          illegal_op = !is_legal_op(opcode);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_RTYPE;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = (op_held == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
        end
        S_I_WB: begin
          reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: state register, next-state logic and
// retired-instruction counter; output decode lives in ctrl_out_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             ready;
  logic             retire;

  assign ready = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      // Held copy of IR opcode: later states must not see opcode changes
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = S_R_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ORI:  state_d = S_I_EXEC;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (ready) state_d = S_MEM_WB;
      S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        if (ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_I_EXEC: state_d = S_I_WB;
      default:  state_d = S_FETCH;
    endcase
  end

  ctrl_out_decode u_dec (
    .reset         (reset),
    .state         (state_q),
    .opcode        (opcode),
    .op_held       (op_q),
    .ready         (ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op)
  );

  assign state_o = reset ? 4'd0 : state_q;
  assign retired = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b1;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, pc_source, alu_op;
  logic [3:0]  state_o;
  logic [31:0] retired;

  multicycle_control #(.MEM_HANDSHAKE(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal_op(illegal_op), .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op}
  localparam logic [16:0] C_ZERO  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FRDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_11_0;
  localparam logic [16:0] C_FWAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_11_0;
  localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_11_0;
  localparam logic [16:0] C_DILL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_11_1;
  localparam logic [16:0] C_MADDR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_11_0;
  localparam logic [16:0] C_MRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_MWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_REX   = 17'b0_0_0_0_0_0_0_0_0_1_00_00_00_0;
  localparam logic [16:0] C_RWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] C_BR    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_JMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;
  localparam logic [16:0] C_IADD  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_11_0;
  localparam logic [16:0] C_IOR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_10_0;
  localparam logic [16:0] C_IWB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] J = 6'b000010, ADDI = 6'b001000, ORI = 6'b001101, BAD = 6'b111111;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec = 0;

  logic [16:0] act_ctl;
  assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 3;
      if (state_o !== e.st) begin
        errors = errors + 1;
        $display("FAIL state vec%0d: got %0d expected %0d", e.idx, state_o, e.st);
      end
      if (act_ctl !== e.ctl) begin
        errors = errors + 1;
        $display("FAIL ctl vec%0d: got %b expected %b", e.idx, act_ctl, e.ctl);
      end
      if (retired !== e.ret) begin
        errors = errors + 1;
        $display("FAIL retired vec%0d: got %0d expected %0d", e.idx, retired, e.ret);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [5:0] opc, input logic rdy,
                     input logic [3:0] es, input logic [16:0] ec, input logic [31:0] er);
    exp_t e;
    reset     = rst;
    opcode    = opc;
    mem_ready = rdy;
    e.st  = es;
    e.ctl = ec;
    e.ret = er;
    e.idx = vec;
    vec   = vec + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset held, outputs all zero
    cyc(1, R, 1, 0, C_ZERO, 0);
    cyc(1, R, 1, 0, C_ZERO, 0);
    // R-type
    cyc(0, R, 1, 0, C_FRDY, 0);
    cyc(0, R, 1, 1, C_DEC,  0);
    cyc(0, R, 1, 6, C_REX,  0);
    cyc(0, R, 1, 7, C_RWB,  0);
    // lw with 3 wait cycles; opcode changed after DECODE must be ignored
    cyc(0, LW, 1, 0, C_FRDY, 1);
    cyc(0, LW, 1, 1, C_DEC,  1);
    cyc(0, R,  1, 2, C_MADDR, 1);
    cyc(0, R,  0, 3, C_MRD,  1);
    cyc(0, R,  0, 3, C_MRD,  1);
    cyc(0, R,  0, 3, C_MRD,  1);
    cyc(0, R,  1, 3, C_MRD,  1);
    cyc(0, R,  1, 4, C_MWB,  1);
    // beq then j
    cyc(0, BEQ, 1, 0, C_FRDY, 2);
    cyc(0, BEQ, 1, 1, C_DEC,  2);
    cyc(0, BEQ, 1, 8, C_BR,   2);
    cyc(0, J,   1, 0, C_FRDY, 3);
    cyc(0, J,   1, 1, C_DEC,  3);
    cyc(0, J,   1, 9, C_JMP,  3);
    // illegal opcode
    cyc(0, BAD, 1, 0, C_FRDY, 4);
    cyc(0, BAD, 1, 1, C_DILL, 4);
    // fetch stall, then ori with opcode switched to addi during I_EXEC
    cyc(0, ORI, 0, 0, C_FWAIT, 4);
    cyc(0, ORI, 1, 0, C_FRDY, 4);
    cyc(0, ORI, 1, 1, C_DEC,  4);
    cyc(0, ADDI, 1, 10, C_IOR, 4);
    cyc(0, ADDI, 1, 11, C_IWB, 4);
    // addi
    cyc(0, ADDI, 1, 0, C_FRDY, 5);
    cyc(0, ADDI, 1, 1, C_DEC,  5);
    cyc(0, ORI,  1, 10, C_IADD, 5);
    cyc(0, ORI,  1, 11, C_IWB, 5);
    // sw with one wait cycle, retires on exit
    cyc(0, SW, 1, 0, C_FRDY, 6);
    cyc(0, SW, 1, 1, C_DEC,  6);
    cyc(0, LW, 1, 2, C_MADDR, 6);
    cyc(0, LW, 0, 5, C_MWR,  6);
    cyc(0, LW, 1, 5, C_MWR,  6);
    // sw interrupted by reset while waiting
    cyc(0, SW, 1, 0, C_FRDY, 7);
    cyc(0, SW, 1, 1, C_DEC,  7);
    cyc(0, SW, 0, 2, C_MADDR, 7);
    cyc(0, SW, 0, 5, C_MWR,  7);
    cyc(1, SW, 0, 0, C_ZERO, 0);
    cyc(0, SW, 0, 0, C_FWAIT, 0);
    cyc(0, SW, 1, 0, C_FRDY, 0);
    repeat (2) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
